// File: rtl/conv_stream_sequencer.sv
// Frame sequencer feeding a conv_layer input stream: paced ready/valid intake, line/frame framing
// and per-line gating on the output-FIFO almost-full flag. Optional stall counter: CONV_SEQ_STALL_STAT_EN.

module conv_stream_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned STRING_LEN  = 224,
  parameter int unsigned CHANNEL_NUM = 3,
  parameter int unsigned STRING_NUM  = 224,
  parameter int unsigned HOLD_DATA   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  input  logic [DATA_WIDTH-1:0]        src_data_i,
  input  logic                         src_valid_i,
  output logic                         src_ready_o,
  input  logic                         ddr_fifo_afull_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o
`ifdef CONV_SEQ_STALL_STAT_EN
  ,
  output logic [31:0]                  stall_cnt_o
`endif
);

  localparam int unsigned WORDS_PER_LINE = STRING_LEN * CHANNEL_NUM;
  localparam int unsigned WORD_W         = $clog2(WORDS_PER_LINE) + 1;
  localparam int unsigned LINE_W         = $clog2(STRING_NUM) + 1;
  localparam int unsigned HOLD_W         = $clog2(HOLD_DATA) + 1;

  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(STRING_NUM - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_DATA - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_LINE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [WORD_W-1:0]       r_word_cnt;
  logic [LINE_W-1:0]       r_line_cnt;
  logic [HOLD_W-1:0]       r_hold_cnt;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_valid;
  logic                    r_sop;
  logic                    r_eop;
  logic                    r_sof;
  logic                    r_eof;
  logic [DATA_WIDTH-1:0]   r_data;

  logic w_ready;
  logic w_accept;
  logic w_start;
  logic w_word_first;
  logic w_word_last;
  logic w_line_first;
  logic w_line_last;

  assign w_ready      = (r_state == S_STREAM) && (r_hold_cnt == '0);
  assign w_accept     = w_ready && src_valid_i;
  assign w_start      = (r_state == S_IDLE) && start_i;
  assign w_word_first = (r_word_cnt == '0);
  assign w_word_last  = (r_word_cnt == WORD_LAST);
  assign w_line_first = (r_line_cnt == '0);
  assign w_line_last  = (r_line_cnt == LINE_LAST);

  // Beat pacing: reload on every accepted word, count down to zero in any state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else if (w_accept) begin
      r_hold_cnt <= HOLD_LOAD;
    end else if (r_hold_cnt != '0) begin
      r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
    end
  end

  // Word/line position within the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_cnt <= '0;
      r_line_cnt <= '0;
    end else if (w_start) begin
      r_word_cnt <= '0;
      r_line_cnt <= '0;
    end else if (w_accept) begin
      if (w_word_last) begin
        r_word_cnt <= '0;
        r_line_cnt <= w_line_last ? '0 : r_line_cnt + LINE_W'(1);
      end else begin
        r_word_cnt <= r_word_cnt + WORD_W'(1);
      end
    end
  end

  // Output beat: one cycle after acceptance; data holds between beats
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_accept;
      r_sop   <= w_accept && w_word_first;
      r_eop   <= w_accept && w_word_last;
      r_sof   <= w_accept && w_word_first && w_line_first;
      r_eof   <= w_accept && w_word_last && w_line_last;
      if (w_accept) begin
        r_data <= src_data_i;
      end
    end
  end

  // Frame control; afull only gates the start of a line, never a line in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_WAIT_LINE;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_LINE: begin
          if (!ddr_fifo_afull_i) begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_accept && w_word_last) begin
            if (w_line_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WAIT_LINE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_SEQ_STALL_STAT_EN
  logic [31:0] r_stall_cnt;

  // Cycles spent blocked by afull at a line start, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_WAIT_LINE) && ddr_fifo_afull_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

  assign src_ready_o  = w_ready;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign data_o       = r_data;
  assign data_valid_o = r_valid;
  assign sop_o        = r_sop;
  assign eop_o        = r_eop;
  assign sof_o        = r_sof;
  assign eof_o        = r_eof;

endmodule

// File: doc/conv_stream_sequencer.md
Name: conv_stream_sequencer

Overview:
- Frame-level controller that feeds a conv_layer input stream from a ready/valid pixel source (DDR reader FIFO).
- Generates data_valid/sop/eop/sof/eof framing and paces beats to at most one every HOLD_DATA cycles, which is the serial convolution throughput.
- Gates the start of each line on the conv_layer output-FIFO almost-full flag, so the layer cannot overrun its DDR write buffer.
- Sits between the input DMA and the first conv_layer of a network stage.

Parameters:
- DATA_WIDTH, 8, pixel/word width.
- STRING_LEN, 224, pixels per line.
- CHANNEL_NUM, 3, words per pixel, interleaved. Words per line = STRING_LEN*CHANNEL_NUM.
- STRING_NUM, 224, lines per frame.
- HOLD_DATA, 16, minimum cycle spacing between accepted words (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  frame start pulse.
- busy_o  out  1  high while state != IDLE.
- done_o  out  1  one-cycle pulse, coincident with eof_o.
- src_data_i  in  DATA_WIDTH  source word.
- src_valid_i  in  1  source word available.
- src_ready_o  out  1  sequencer accepts word this cycle.
- ddr_fifo_afull_i  in  1  almost-full from conv_layer output FIFO.
- data_o  out  DATA_WIDTH  word to conv_layer (signed).
- data_valid_o  out  1  word strobe.
- sop_o, eop_o, sof_o, eof_o  out  1 each  first/last word of line, first/last word of frame.

Behaviour:
- Reset (sync, highest priority): state=IDLE, all counters 0. All outputs 0: data_o, data_valid_o, flags, busy_o, done_o, src_ready_o.
- FSM states: IDLE, WAIT_LINE, STREAM, DONE.
  - IDLE: start_i=1 -> WAIT_LINE; clears word/line counters.
  - WAIT_LINE: ddr_fifo_afull_i=0 -> STREAM; otherwise stay.
  - STREAM: when last word of line is accepted -> DONE if last line, else WAIT_LINE.
  - DONE: one cycle -> IDLE.
- start_i outside IDLE is ignored.
- Handshake: src_ready_o = (state==STREAM) && (hold_cnt==0), combinational from registers. A word is accepted when src_valid_i && src_ready_o.
- Latency: an accepted word in cycle t appears on data_o with data_valid_o=1 in cycle t+1.
  - Flags are valid only with data_valid_o; all are 0 otherwise.
  - data_o holds its last value when not valid.
- Pacing:
  - On acceptance, hold_cnt loads HOLD_DATA-1.
  - hold_cnt decrements each cycle toward 0, saturating at 0, in every state.
  - Accepted words are therefore >= HOLD_DATA cycles apart. HOLD_DATA=1 allows back-to-back words.
- Source stall: src_valid_i=0 with ready high -> no beat; counters hold; no timeout.
- Counters:
  - word_cnt counts 0..STRING_LEN*CHANNEL_NUM-1 and wraps to 0 at line end.
  - line_cnt counts 0..STRING_NUM-1.
  - Widths are $clog2(max)+1.
- Flags:
  - sop on word_cnt==0; eop on word_cnt==last.
  - sof on sop of line 0; eof on eop of last line.
  - With a single-word line, sop and eop are set on the same beat.
- afull is sampled only in WAIT_LINE. A line in progress always completes, relying on the FIFO half-full margin. afull mid-line only delays the next line.
- done_o: the DONE cycle coincides with the eof beat output.
- Reset mid-frame: immediate return to IDLE, no eof or done emitted, partial frame discarded. The next start_i begins a fresh frame with sof.

Optional Feature:
- Macro CONV_SEQ_STALL_STAT_EN.
- Defined: adds output stall_cnt_o [31:0].
  - Counts cycles in WAIT_LINE with ddr_fifo_afull_i=1, saturating at 2^32-1.
  - Cleared by reset and on start acceptance; holds after done.
- Undefined: port and counter absent; other behaviour identical.

Test Plan (STRING_LEN=4, CHANNEL_NUM=1, STRING_NUM=2, HOLD_DATA=3 unless noted):
- Basic frame: afull=0, src always valid, start at t0 -> first data_valid_o at t0+3; 8 beats exactly 3 cycles apart. sop on beats 1,5; eop on 4,8; sof on 1; eof and done_o on 8; busy_o low the cycle after.
- afull high from start, released at cycle r -> src_ready_o first high at r+1, first beat at r+2; no valid before.
- afull raised after beat 2, dropped 20 cycles later -> beats 3-4 still spaced 3 cycles. Beat 5 (sop) appears 2 cycles after release, or later if hold is still running.
- src_valid_i low for 10 cycles mid-line -> no beats, counters hold; resumes with correct flags and no duplicated or lost words (data sequence 1..8 checked).
- Reset pulse after beat 3, then start -> outputs 0 the cycle after reset. New frame starts with sof on beat 1; no eof or done from the aborted frame. start_i during busy is ignored.
- HOLD_DATA=1, CHANNEL_NUM=3, STRING_LEN=1 -> back-to-back beats. sop on beats 1,4; eop on 3,6; eof on 6. With CONV_SEQ_STALL_STAT_EN and afull high 7 cycles in WAIT_LINE -> stall_cnt_o=7.
